// File: rtl/wd_bus_sequencer.sv
// Two-requester front end for the watchdog ABUS/DBUS write port: round-robin
// arbitration, KEY/gap/write unlock replay, fail lockout and reserved-address rejection.
module wd_bus_sequencer #(
    parameter logic [15:0] KEY     = 16'hA5C3,
    parameter int unsigned KEY_GAP = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ0,
    input  logic [1:0]  ADDR0,
    input  logic [15:0] DATA0,
    input  logic        REQ1,
    input  logic [1:0]  ADDR1,
    input  logic [15:0] DATA1,
    input  logic        WDFAIL,
    output logic [1:0]  ABUS,
    output logic [15:0] DBUS,
    output logic [1:0]  GNT,
    output logic [1:0]  ACK,
    output logic [1:0]  NACK,
    output logic        BUSY
);

    localparam logic [1:0] RSVD_ADDR = 2'b10;
    localparam bit         HAS_GAP   = (KEY_GAP != 0);
    localparam logic [3:0] GAP_LOAD  = (KEY_GAP == 0) ? 4'd0 : 4'(KEY_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_GAP,
        S_WRITE,
        S_DONE
    } state_e;

    state_e      state_q;
    logic        ptr_q;
    logic        idx_q;
    logic [1:0]  addr_q;
    logic [15:0] data_q;
    logic [3:0]  gap_cnt_q;
    logic [1:0]  abus_q;
    logic [15:0] dbus_q;
    logic [1:0]  gnt_q;
    logic [1:0]  ack_q;
    logic [1:0]  nack_q;
    logic        busy_q;

    logic [1:0]  cand;
    logic        win;
    logic [1:0]  win_oh;
    logic [1:0]  win_addr;
    logic [15:0] win_data;

    // A requester whose ACK/NACK pulse is high this cycle sits out one evaluation.
    always_comb begin
        cand     = {REQ1 & ~ack_q[1] & ~nack_q[1], REQ0 & ~ack_q[0] & ~nack_q[0]};
        win      = (cand == 2'b11) ? ~ptr_q : cand[1];
        win_oh   = win ? 2'b10 : 2'b01;
        win_addr = win ? ADDR1 : ADDR0;
        win_data = win ? DATA1 : DATA0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b1;
            idx_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            gap_cnt_q <= '0;
            abus_q    <= '0;
            dbus_q    <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            nack_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            ack_q  <= '0;
            nack_q <= '0;
            if (WDFAIL && (state_q == S_KEY || state_q == S_GAP || state_q == S_WRITE)) begin
                state_q <= S_IDLE;
                abus_q  <= '0;
                dbus_q  <= '0;
                gnt_q   <= '0;
                nack_q  <= gnt_q;
                ptr_q   <= idx_q;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    // DONE is the bus-idle ACK cycle; arbitration already runs in it,
                    // so the next grant can land on the edge that ends the ACK pulse.
                    S_IDLE, S_DONE: begin
                        state_q <= S_IDLE;
                        abus_q  <= '0;
                        dbus_q  <= '0;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        if (WDFAIL) begin
                            nack_q <= cand;
                        end else if (cand != 2'b00) begin
                            if (win_addr == RSVD_ADDR) begin
                                nack_q <= win_oh;
                            end else begin
                                state_q <= S_KEY;
                                idx_q   <= win;
                                addr_q  <= win_addr;
                                data_q  <= win_data;
                                gnt_q   <= win_oh;
                                dbus_q  <= KEY;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    S_KEY: begin
                        if (HAS_GAP) begin
                            state_q   <= S_GAP;
                            gap_cnt_q <= GAP_LOAD;
                            abus_q    <= '0;
                            dbus_q    <= '0;
                        end else begin
                            state_q <= S_WRITE;
                            abus_q  <= addr_q;
                            dbus_q  <= data_q;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt_q == 4'd0) begin
                            state_q <= S_WRITE;
                            abus_q  <= addr_q;
                            dbus_q  <= data_q;
                        end else begin
                            gap_cnt_q <= gap_cnt_q - 4'd1;
                        end
                    end
                    S_WRITE: begin
                        state_q <= S_DONE;
                        abus_q  <= '0;
                        dbus_q  <= '0;
                        ack_q   <= gnt_q;
                        gnt_q   <= '0;
                        ptr_q   <= idx_q;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        abus_q  <= '0;
                        dbus_q  <= '0;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ABUS = abus_q;
    assign DBUS = dbus_q;
    assign GNT  = gnt_q;
    assign ACK  = ack_q;
    assign NACK = nack_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_wd_bus_sequencer.sv
// Directed bench for wd_bus_sequencer: KEY_GAP=1 main instance plus KEY_GAP=0 and 15 instances.
module tb_wd_bus_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        REQ0 = 1'b0, REQ1 = 1'b0, WDFAIL = 1'b0;
    logic [1:0]  ADDR0 = '0, ADDR1 = '0;
    logic [15:0] DATA0 = '0, DATA1 = '0;

    logic [1:0]  abus1, gnt1, ack1, nack1;
    logic [15:0] dbus1;
    logic        busy1;
    logic [1:0]  abus0, gnt0, ack0, nack0;
    logic [15:0] dbus0;
    logic        busy0;
    logic [1:0]  abus15, gnt15, ack15, nack15;
    logic [15:0] dbus15;
    logic        busy15;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    wd_bus_sequencer #(.KEY(16'hA5C3), .KEY_GAP(1)) u_dut (
        .CLK(CLK), .RST(RST), .REQ0(REQ0), .ADDR0(ADDR0), .DATA0(DATA0),
        .REQ1(REQ1), .ADDR1(ADDR1), .DATA1(DATA1), .WDFAIL(WDFAIL),
        .ABUS(abus1), .DBUS(dbus1), .GNT(gnt1), .ACK(ack1), .NACK(nack1), .BUSY(busy1));

    wd_bus_sequencer #(.KEY(16'hA5C3), .KEY_GAP(0)) u_g0 (
        .CLK(CLK), .RST(RST), .REQ0(REQ0), .ADDR0(ADDR0), .DATA0(DATA0),
        .REQ1(REQ1), .ADDR1(ADDR1), .DATA1(DATA1), .WDFAIL(WDFAIL),
        .ABUS(abus0), .DBUS(dbus0), .GNT(gnt0), .ACK(ack0), .NACK(nack0), .BUSY(busy0));

    wd_bus_sequencer #(.KEY(16'hA5C3), .KEY_GAP(15)) u_g15 (
        .CLK(CLK), .RST(RST), .REQ0(REQ0), .ADDR0(ADDR0), .DATA0(DATA0),
        .REQ1(REQ1), .ADDR1(ADDR1), .DATA1(DATA1), .WDFAIL(WDFAIL),
        .ABUS(abus15), .DBUS(dbus15), .GNT(gnt15), .ACK(ack15), .NACK(nack15), .BUSY(busy15));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; WDFAIL = 1'b0;
        ADDR0 = '0; ADDR1 = '0; DATA0 = '0; DATA1 = '0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_abus"}, 32'(abus1), 0);
        chk({tag, "_dbus"}, 32'(dbus1), 0);
        chk({tag, "_gnt"},  32'(gnt1),  0);
        chk({tag, "_ack"},  32'(ack1),  0);
        chk({tag, "_nack"}, 32'(nack1), 0);
        chk({tag, "_busy"}, 32'(busy1), 0);
    endtask

    initial begin
        int order[$];
        int acks_a, acks_b;
        logic [1:0] gprev;

        // Reset values
        #2;
        chk_all_zero("reset");
        do_reset();

        // Single write, KEY_GAP=1
        REQ0 = 1'b1; ADDR0 = 2'b01; DATA0 = 16'h0123;
        tick();
        chk("sw_t0_gnt",  32'(gnt1),  'h1);
        chk("sw_t0_dbus", 32'(dbus1), 'hA5C3);
        chk("sw_t0_abus", 32'(abus1), 'h0);
        chk("sw_t0_busy", 32'(busy1), 'h1);
        REQ0 = 1'b0; ADDR0 = 2'b11; DATA0 = 16'hFFFF;
        tick();
        chk("sw_t1_dbus", 32'(dbus1), 'h0);
        chk("sw_t1_gnt",  32'(gnt1),  'h1);
        tick();
        chk("sw_t2_abus", 32'(abus1), 'h1);
        chk("sw_t2_dbus", 32'(dbus1), 'h0123);
        chk("sw_t2_ack",  32'(ack1),  'h0);
        tick();
        chk("sw_t3_ack",  32'(ack1),  'h1);
        chk("sw_t3_gnt",  32'(gnt1),  'h0);
        chk("sw_t3_dbus", 32'(dbus1), 'h0);
        tick();
        chk("sw_t4_ack",  32'(ack1),  'h0);
        chk("sw_t4_busy", 32'(busy1), 'h0);

        // Contention: three writes each, alternating grants
        do_reset();
        acks_a = 0; acks_b = 0; gprev = '0;
        REQ0 = 1'b1; ADDR0 = 2'b01; DATA0 = 16'h1111;
        REQ1 = 1'b1; ADDR1 = 2'b11; DATA1 = 16'h2222;
        for (int c = 0; c < 60 && (acks_a < 3 || acks_b < 3); c++) begin
            tick();
            chk("ct_gnt_onehot", 32'($countones(gnt1) <= 1), 1);
            if (gnt1 != 2'b00 && gprev == 2'b00) order.push_back(gnt1[1] ? 1 : 0);
            gprev = gnt1;
            if (ack1 != 2'b00) chk("ct_idle_bus", 32'({abus1, dbus1}), 0);
            if (ack1[0]) begin acks_a++; if (acks_a == 3) REQ0 = 1'b0; end
            if (ack1[1]) begin acks_b++; if (acks_b == 3) REQ1 = 1'b0; end
        end
        chk("ct_acks0", 32'(acks_a), 3);
        chk("ct_acks1", 32'(acks_b), 3);
        chk("ct_order_len", 32'(order.size()), 6);
        for (int i = 0; i < 6; i++)
            chk("ct_order", 32'((i < order.size()) ? order[i] : -1), 32'(i % 2));

        // Reserved address, alone and with a valid competitor
        do_reset();
        REQ1 = 1'b1; ADDR1 = 2'b10; DATA1 = 16'h7777;
        tick();
        chk("rs_nack", 32'(nack1), 'h2);
        chk("rs_gnt",  32'(gnt1),  'h0);
        chk("rs_dbus", 32'(dbus1), 'h0);
        REQ1 = 1'b0;
        tick();
        chk("rs_nack_pulse", 32'(nack1), 'h0);
        chk("rs_busy",       32'(busy1), 'h0);
        REQ0 = 1'b1; ADDR0 = 2'b10;
        REQ1 = 1'b1; ADDR1 = 2'b01; DATA1 = 16'hBEEF;
        tick();
        chk("rs2_nack", 32'(nack1), 'h1);
        chk("rs2_gnt",  32'(gnt1),  'h0);
        REQ0 = 1'b0;
        tick();
        chk("rs2_gnt1", 32'(gnt1),  'h2);
        chk("rs2_key",  32'(dbus1), 'hA5C3);
        REQ1 = 1'b0;
        tick();
        tick();
        chk("rs2_write", 32'({abus1, dbus1}), 'h1BEEF);
        tick();
        chk("rs2_ack", 32'(ack1), 'h2);

        // Fail lockout, then abort during GAP
        do_reset();
        WDFAIL = 1'b1;
        REQ0 = 1'b1; ADDR0 = 2'b01; REQ1 = 1'b1; ADDR1 = 2'b01;
        tick();
        chk("fl_nack", 32'(nack1), 'h3);
        chk("fl_gnt",  32'(gnt1),  'h0);
        tick();
        chk("fl_nack_gap", 32'(nack1), 'h0);
        tick();
        chk("fl_nack_again", 32'(nack1), 'h3);
        REQ0 = 1'b0; REQ1 = 1'b0; WDFAIL = 1'b0;
        tick();
        REQ0 = 1'b1; ADDR0 = 2'b11; DATA0 = 16'h5555;
        tick();
        chk("ab_gnt", 32'(gnt1), 'h1);
        REQ0 = 1'b0;
        tick();
        chk("ab_gap", 32'(dbus1), 'h0);
        WDFAIL = 1'b1;
        tick();
        chk("ab_nack", 32'(nack1), 'h1);
        chk("ab_gnt0", 32'(gnt1),  'h0);
        chk("ab_bus",  32'({abus1, dbus1}), 'h0);
        chk("ab_ack",  32'(ack1),  'h0);
        chk("ab_busy", 32'(busy1), 'h0);
        WDFAIL = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ab_no_write", 32'({abus1, dbus1}), 'h0);
            chk("ab_no_ack",   32'(ack1), 'h0);
        end

        // KEY_GAP=0 and KEY_GAP=15 instances, one write each
        do_reset();
        REQ0 = 1'b1; ADDR0 = 2'b11; DATA0 = 16'h1234;
        tick();
        REQ0 = 1'b0;
        chk("g0_key",  32'(dbus0),  'hA5C3);
        chk("g15_key", 32'(dbus15), 'hA5C3);
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 1) chk("g0_write", 32'({abus0, dbus0}), 'h31234);
            if (i == 2) chk("g0_ack",   32'(ack0), 'h1);
            if (i < 16) chk("g15_gap",  32'({ack15, abus15, dbus15}), 'h0);
            if (i == 16) chk("g15_write", 32'({abus15, dbus15}), 'h31234);
            if (i == 17) chk("g15_ack",   32'(ack15), 'h1);
        end

        // Async reset during WRITE, then tie resolved to requester 0
        do_reset();
        REQ0 = 1'b1; ADDR0 = 2'b01; DATA0 = 16'hABCD;
        tick();
        tick();
        tick();
        chk("rw_in_write", 32'({abus1, dbus1}), 'h1ABCD);
        #2;
        RST = 1'b0;
        #1;
        chk_all_zero("rw_async");
        REQ1 = 1'b1; ADDR1 = 2'b01; DATA1 = 16'h4321;
        #2;
        RST = 1'b1;
        tick();
        chk("rw_first_gnt", 32'(gnt1), 'h1);
        REQ0 = 1'b0; REQ1 = 1'b0;
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
